interrupt_sequencer: RTL

Sequences the 6502 core's shared datapath through interrupt, BRK and reset entry. At an instruction boundary it takes over the bus and stack-pointer controls from the main control unit, pushes PCH/PCL/P (or suppresses the pushes on reset), and loads PC from the selected vector. It sits beside the control unit and holds it via `busy`. The datapath muxes select the sequencer's controls whenever `busy=1`.

---
 rtl/interrupt_sequencer_pkg.sv | 82 ++++++++
 rtl/interrupt_sequencer_if.sv | 38 +++
 rtl/interrupt_sequencer_int_request_latch.sv | 68 ++++++
 rtl/interrupt_sequencer.sv | 79 +++++++
 4 files changed

// File: rtl/interrupt_sequencer_pkg.sv
// Shared encodings, vector constants and output decode for the 6502
// interrupt/BRK/reset entry sequencer.
package cpu_pkg;

  typedef enum logic [1:0] {
    CAUSE_RESET = 2'd0,
    CAUSE_NMI   = 2'd1,
    CAUSE_IRQ   = 2'd2,
    CAUSE_BRK   = 2'd3
  } cause_t;

  localparam logic [1:0] ADDR_PC     = 2'd0;
  localparam logic [1:0] ADDR_STACK  = 2'd1;
  localparam logic [1:0] ADDR_VECTOR = 2'd2;

  localparam logic [1:0] DATA_PCH = 2'd0;
  localparam logic [1:0] DATA_PCL = 2'd1;
  localparam logic [1:0] DATA_P   = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_PUSH_H = 3'd1,
    ST_PUSH_L = 3'd2,
    ST_PUSH_P = 3'd3,
    ST_VEC_L  = 3'd4,
    ST_VEC_H  = 3'd5
  } seq_state_t;

  localparam logic [15:0] VEC_NMI = 16'hFFFA;
  localparam logic [15:0] VEC_RST = 16'hFFFC;
  localparam logic [15:0] VEC_IRQ = 16'hFFFE;

  typedef struct packed {
    logic        read_write;
    logic [1:0]  addr_sel;
    logic [15:0] vector_addr;
    logic [1:0]  data_sel;
    logic        sp_dec;
    logic        pcl_load;
    logic        pch_load;
    logic        set_i;
    logic        b_flag;
  } seq_ctrl_t;

  function automatic logic [15:0] vector_base(cause_t c);
    case (c)
      CAUSE_NMI:   return VEC_NMI;
      CAUSE_RESET: return VEC_RST;
      default:     return VEC_IRQ;
    endcase
  endfunction

  // Datapath controls for a given state; reset entry turns pushes into dummy reads.
  function automatic seq_ctrl_t decode_ctrl(seq_state_t s, cause_t c);
    seq_ctrl_t o;
    o = '0;
    case (s)
      ST_PUSH_H, ST_PUSH_L, ST_PUSH_P: begin
        o.addr_sel   = ADDR_STACK;
        o.sp_dec     = 1'b1;
        o.read_write = (c != CAUSE_RESET);
        o.data_sel   = (s == ST_PUSH_H) ? DATA_PCH :
                       (s == ST_PUSH_L) ? DATA_PCL : DATA_P;
        o.b_flag     = (s == ST_PUSH_P) && (c == CAUSE_BRK);
      end
      ST_VEC_L: begin
        o.addr_sel    = ADDR_VECTOR;
        o.vector_addr = vector_base(c);
        o.pcl_load    = 1'b1;
        o.set_i       = 1'b1;
      end
      ST_VEC_H: begin
        o.addr_sel    = ADDR_VECTOR;
        o.vector_addr = vector_base(c) + 16'd1;
        o.pch_load    = 1'b1;
      end
      default: o = '0;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/interrupt_sequencer_if.sv
// Request inputs and datapath control outputs shared between the control
// unit (master) and the interrupt sequencer (slave).
interface interrupt_sequencer_if;
  import cpu_pkg::*;

  logic        boundary;
  logic        brk;
  logic        nmi;
  logic        irq;
  logic        i_flag;
  logic        busy;
  logic        read_write;
  logic [1:0]  addr_sel;
  logic [15:0] vector_addr;
  logic [1:0]  data_sel;
  logic        sp_dec;
  logic        pcl_load;
  logic        pch_load;
  logic        set_i;
  logic        b_flag;
  cause_t      cause;
  seq_state_t  dbg_state;

  // No valid/ready pair here: busy=1 means the sequencer owns the bus and
  // the control unit must hold; requests are sampled only while busy is low
  // (except pending reset, which forces busy high until it is consumed).
  modport slave (
    input  boundary, brk, nmi, irq, i_flag,
    output busy, read_write, addr_sel, vector_addr, data_sel, sp_dec,
           pcl_load, pch_load, set_i, b_flag, cause, dbg_state
  );

  modport master (
    output boundary, brk, nmi, irq, i_flag,
    input  busy, read_write, addr_sel, vector_addr, data_sel, sp_dec,
           pcl_load, pch_load, set_i, b_flag, cause, dbg_state
  );
endinterface

// File: rtl/interrupt_sequencer_int_request_latch.sv
// NMI edge capture, pending reset/NMI flags and the entry priority encoder.
module int_request_latch
  import cpu_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   nmi,
  input  logic   boundary,
  input  logic   brk,
  input  logic   irq,
  input  logic   i_flag,
  input  logic   idle,
  output logic   take,
  output cause_t take_cause,
  output logic   reset_pend
);

  logic nmi_prev_q;
  logic nmi_pend_q, nmi_pend_d;
  logic reset_pend_q, reset_pend_d;
  logic nmi_rise;

  assign nmi_rise   = nmi & ~nmi_prev_q;
  assign reset_pend = reset_pend_q;

  always_comb begin
    take       = 1'b0;
    take_cause = CAUSE_RESET;
    if (idle) begin
      if (reset_pend_q) begin
        take = 1'b1;
      end else if (boundary) begin
        if (nmi_pend_q) begin
          take       = 1'b1;
          take_cause = CAUSE_NMI;
        end else if (brk) begin
          take       = 1'b1;
          take_cause = CAUSE_BRK;
        end else if (irq & ~i_flag) begin
          take       = 1'b1;
          take_cause = CAUSE_IRQ;
        end
      end
    end
  end

  // A fresh edge in the consuming cycle keeps the NMI pending.
  always_comb begin
    nmi_pend_d   = nmi_pend_q;
    reset_pend_d = reset_pend_q;
    if (take && take_cause == CAUSE_NMI)   nmi_pend_d   = 1'b0;
    if (nmi_rise)                          nmi_pend_d   = 1'b1;
    if (take && take_cause == CAUSE_RESET) reset_pend_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      nmi_prev_q   <= 1'b0;
      nmi_pend_q   <= 1'b0;
      reset_pend_q <= 1'b1;
    end else begin
      nmi_prev_q   <= nmi;
      nmi_pend_q   <= nmi_pend_d;
      reset_pend_q <= reset_pend_d;
    end
  end

endmodule

// File: rtl/interrupt_sequencer.sv
// Takes over the 6502 datapath at an instruction boundary to push PC/P and
// fetch the interrupt, BRK or reset vector.
module interrupt_sequencer
  import cpu_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  interrupt_sequencer_if.slave  bus
);

  seq_state_t state_q, state_d;
  cause_t     cause_q, cause_d;
  seq_ctrl_t  ctrl_q;
  logic       idle;
  logic       take;
  cause_t     take_cause;
  logic       reset_pend;

  assign idle = (state_q == ST_IDLE);

  int_request_latch u_req (
    .clk        (clk),
    .rst        (rst),
    .nmi        (bus.nmi),
    .boundary   (bus.boundary),
    .brk        (bus.brk),
    .irq        (bus.irq),
    .i_flag     (bus.i_flag),
    .idle       (idle),
    .take       (take),
    .take_cause (take_cause),
    .reset_pend (reset_pend)
  );

  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    case (state_q)
      ST_IDLE: begin
        if (take) begin
          state_d = ST_PUSH_H;
          cause_d = take_cause;
        end
      end
      ST_PUSH_H: state_d = ST_PUSH_L;
      ST_PUSH_L: state_d = ST_PUSH_P;
      ST_PUSH_P: state_d = ST_VEC_L;
      ST_VEC_L:  state_d = ST_VEC_H;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Controls are registered from the next state so they line up with state_q.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cause_q <= CAUSE_RESET;
      ctrl_q  <= '0;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      ctrl_q  <= decode_ctrl(state_d, cause_d);
    end
  end

  assign bus.busy        = ~idle | reset_pend;
  assign bus.read_write  = ctrl_q.read_write;
  assign bus.addr_sel    = ctrl_q.addr_sel;
  assign bus.vector_addr = ctrl_q.vector_addr;
  assign bus.data_sel    = ctrl_q.data_sel;
  assign bus.sp_dec      = ctrl_q.sp_dec;
  assign bus.pcl_load    = ctrl_q.pcl_load;
  assign bus.pch_load    = ctrl_q.pch_load;
  assign bus.set_i       = ctrl_q.set_i;
  assign bus.b_flag      = ctrl_q.b_flag;
  assign bus.cause       = cause_q;
  assign bus.dbg_state   = state_q;

endmodule
